// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Multiplexed seven-segment scanner with frame-synchronous
//               loading, per-digit blank/blink and PWM brightness.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SEG_W      = 7,
  parameter int SCAN_DIV   = 100000,
  parameter int BRIGHT_W   = 3,
  parameter int BLINK_HALF = 50000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [NUM_DIGITS-1:0]       blink_en,
  input  logic [BRIGHT_W-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]       an_out,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        pending,
  output logic                        applied,
  output logic                        frame_start
);

  localparam int c_sub_len = SCAN_DIV / (2 ** BRIGHT_W);
  localparam int c_sub_w   = (c_sub_len > 1) ? $clog2(c_sub_len) : 1;
  localparam int c_idx_w   = $clog2(NUM_DIGITS);
  localparam int c_blk_w   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [c_sub_w-1:0]  c_sub_max = c_sub_w'(c_sub_len - 1);
  localparam logic [BRIGHT_W-1:0] c_ph_max  = '1;
  localparam logic [c_idx_w-1:0]  c_idx_max = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [c_blk_w-1:0]  c_blk_max = c_blk_w'(BLINK_HALF - 1);

  logic [c_sub_w-1:0]          sub_cnt_q, sub_cnt_d;
  logic [BRIGHT_W-1:0]         phase_q, phase_d;
  logic [c_idx_w-1:0]          idx_q, idx_d;
  logic [c_blk_w-1:0]          blink_cnt_q, blink_cnt_d;
  logic                        blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS*SEG_W-1:0] stage_seg_q, stage_seg_d;
  logic [NUM_DIGITS-1:0]       stage_en_q, stage_en_d;
  logic [NUM_DIGITS-1:0]       stage_blink_q, stage_blink_d;
  logic [NUM_DIGITS*SEG_W-1:0] active_seg_q, active_seg_d;
  logic [NUM_DIGITS-1:0]       active_en_q, active_en_d;
  logic [NUM_DIGITS-1:0]       active_blink_q, active_blink_d;
  logic                        pending_q, pending_d;
  logic                        applied_q, applied_d;
  logic                        frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [SEG_W-1:0]            seg_q, seg_d;

  logic             w_sub_wrap;
  logic             w_tick;
  logic             w_commit;
  logic             w_blk_wrap;
  logic             w_lit;
  logic [SEG_W-1:0] w_seg;

  always_comb begin
    w_sub_wrap = (sub_cnt_q == c_sub_max);
    w_tick     = w_sub_wrap && (phase_q == c_ph_max);
    w_commit   = w_tick && (idx_q == c_idx_max) && pending_q;
    w_blk_wrap = (blink_cnt_q == c_blk_max);
    w_seg      = active_seg_q[int'(idx_q)*SEG_W +: SEG_W];
    w_lit      = active_en_q[idx_q] && (phase_q <= brightness) &&
                 !(blink_phase_q && active_blink_q[idx_q]);

    sub_cnt_d     = w_sub_wrap ? '0 : sub_cnt_q + 1'b1;
    phase_d       = w_sub_wrap ? phase_q + 1'b1 : phase_q;
    idx_d         = idx_q;
    if (w_tick) begin
      idx_d = (idx_q == c_idx_max) ? '0 : idx_q + 1'b1;
    end
    blink_cnt_d   = w_blk_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ w_blk_wrap;

    // Commit reads the pre-load staging value, so a same-cycle load stays pending
    stage_seg_d    = stage_seg_q;
    stage_en_d     = stage_en_q;
    stage_blink_d  = stage_blink_q;
    active_seg_d   = active_seg_q;
    active_en_d    = active_en_q;
    active_blink_d = active_blink_q;
    if (load) begin
      stage_seg_d   = seg_in;
      stage_en_d    = digit_en;
      stage_blink_d = blink_en;
    end
    if (w_commit) begin
      active_seg_d   = stage_seg_q;
      active_en_d    = stage_en_q;
      active_blink_d = stage_blink_q;
    end
    pending_d     = load || (pending_q && !w_commit);
    applied_d     = w_commit;
    frame_start_d = (idx_q == '0) && (sub_cnt_q == '0) && (phase_q == '0);

    an_d  = w_lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d = w_lit ? ~w_seg : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt_q      <= '0;
      phase_q        <= '0;
      idx_q          <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      stage_seg_q    <= '0;
      stage_en_q     <= '0;
      stage_blink_q  <= '0;
      active_seg_q   <= '0;
      active_en_q    <= '0;
      active_blink_q <= '0;
      pending_q      <= 1'b0;
      applied_q      <= 1'b0;
      frame_start_q  <= 1'b0;
      an_q           <= '1;
      seg_q          <= '1;
    end else begin
      sub_cnt_q      <= sub_cnt_d;
      phase_q        <= phase_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      stage_seg_q    <= stage_seg_d;
      stage_en_q     <= stage_en_d;
      stage_blink_q  <= stage_blink_d;
      active_seg_q   <= active_seg_d;
      active_en_q    <= active_en_d;
      active_blink_q <= active_blink_d;
      pending_q      <= pending_d;
      applied_q      <= applied_d;
      frame_start_q  <= frame_start_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
    end
  end

  assign an_out      = an_q;
  assign seg_out     = seg_q;
  assign pending     = pending_q;
  assign applied     = applied_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seven_seg_scan_ctrl
// Description : Self-checking bench for seven_seg_scan_ctrl (4 digits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [27:0] seg_in;
  logic [3:0]  digit_en;
  logic [3:0]  blink_en;
  logic [1:0]  brightness;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        pending;
  logic        applied;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4), .SEG_W(7), .SCAN_DIV(8), .BRIGHT_W(2), .BLINK_HALF(64)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .seg_in(seg_in), .digit_en(digit_en),
    .blink_en(blink_en), .brightness(brightness), .an_out(an_out),
    .seg_out(seg_out), .pending(pending), .applied(applied),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge
  logic        s_rst = 1'b0;
  logic        s_load;
  logic [27:0] s_seg;
  logic [3:0]  s_den, s_ben;
  logic [1:0]  s_bri;
  always @(posedge clk) begin
    s_rst  <= rst;
    s_load <= load;
    s_seg  <= seg_in;
    s_den  <= digit_en;
    s_ben  <= blink_en;
    s_bri  <= brightness;
  end

  // Reference model: m_t counts clocks since reset; slot = 8 clocks,
  // PWM phase = 2 clocks, frame = 32 clocks, blink half-period = 64 clocks.
  int         m_t = 0;
  bit         m_valid = 1'b0;
  bit         m_pending;
  logic [6:0] m_stage_seg [4];
  logic [6:0] m_act_seg   [4];
  logic [3:0] m_stage_en, m_stage_bl, m_act_en, m_act_bl;

  always @(negedge clk) begin : model
    int         idx, ph, bp;
    bit         lit, e_app, e_fs;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    if (s_rst === 1'b1) begin
      m_t = 0;
      m_pending = 1'b0;
      m_stage_en = '0; m_stage_bl = '0; m_act_en = '0; m_act_bl = '0;
      for (int i = 0; i < 4; i++) begin
        m_stage_seg[i] = '0;
        m_act_seg[i]   = '0;
      end
      m_valid = 1'b1;
      chk("rst_an", an_out, 4'hF);
      chk("rst_seg", seg_out, 7'h7F);
      chk("rst_pending", pending, 1'b0);
      chk("rst_applied", applied, 1'b0);
    end else if (m_valid) begin
      idx = (m_t / 8) % 4;
      ph  = (m_t % 8) / 2;
      bp  = (m_t / 64) % 2;
      lit = m_act_en[idx] && (ph <= int'(s_bri)) && !(bp == 1 && m_act_bl[idx]);
      e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
      e_seg = lit ? ~m_act_seg[idx] : 7'h7F;
      e_fs  = (m_t % 32 == 0);
      e_app = (m_t % 32 == 31) && m_pending;
      if (e_app) begin
        for (int i = 0; i < 4; i++) m_act_seg[i] = m_stage_seg[i];
        m_act_en  = m_stage_en;
        m_act_bl  = m_stage_bl;
        m_pending = 1'b0;
      end
      if (s_load) begin
        for (int i = 0; i < 4; i++) m_stage_seg[i] = s_seg[i*7 +: 7];
        m_stage_en = s_den;
        m_stage_bl = s_ben;
        m_pending  = 1'b1;
      end
      m_t++;
      chk("model_an", an_out, e_an);
      chk("model_seg", seg_out, e_seg);
      chk("model_pending", pending, m_pending);
      chk("model_applied", applied, e_app);
      chk("model_frame_start", frame_start, e_fs);
      chk("onehot_an", ($countones(~an_out) <= 1), 1'b1);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_applied(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 80 && !ok; n++) begin
      tick();
      if (applied) ok = 1'b1;
    end
  endtask

  task automatic wait_mod(input int m);
    for (int n = 0; n < 64 && (m_t % 32) != m; n++) tick();
  endtask

  typedef struct {
    logic [3:0]      den;
    logic [1:0]      bri;
    logic [3:0][7:0] exp_cnt;
  } vec_t;

  localparam logic [27:0] BASIC = {7'h06, 7'h5B, 7'h4F, 7'h66};

  initial begin
    vec_t vecs [4];
    bit   ok;
    int   cnt [4];
    int   n;
    vecs[0] = '{4'b0101, 2'd3, {8'd0, 8'd8, 8'd0, 8'd8}};
    vecs[1] = '{4'b1111, 2'd1, {8'd4, 8'd4, 8'd4, 8'd4}};
    vecs[2] = '{4'b1010, 2'd0, {8'd2, 8'd0, 8'd2, 8'd0}};
    vecs[3] = '{4'b1111, 2'd3, {8'd8, 8'd8, 8'd8, 8'd8}};

    rst = 1'b1; load = 1'b0; seg_in = '0; digit_en = '0; blink_en = '0; brightness = 2'd3;
    repeat (3) tick();
    chk("reset_an", an_out, 4'hF);
    chk("reset_seg", seg_out, 7'h7F);
    chk("reset_pending", pending, 1'b0);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (an_out != 4'hF) n++;
    end
    chk("idle_no_anode", n, 0);

    // Table: load a configuration, then count anode-low cycles over one frame
    for (int v = 0; v < 4; v++) begin
      seg_in = BASIC; digit_en = vecs[v].den; blink_en = '0; brightness = vecs[v].bri;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("pending_after_load", pending, 1'b1);
      wait_applied(ok);
      chk("applied_seen", ok, 1'b1);
      for (int d = 0; d < 4; d++) cnt[d] = 0;
      for (int k = 0; k < 32; k++) begin
        tick();
        for (int d = 0; d < 4; d++) if (!an_out[d]) cnt[d]++;
        if (an_out == 4'hE) chk("digit0_seg", seg_out, 7'h19);
        if (an_out == 4'h7) chk("digit3_seg", seg_out, 7'h79);
      end
      for (int d = 0; d < 4; d++) chk("low_count", cnt[d], 32'(vecs[v].exp_cnt[d]));
    end

    n = 0;
    while (!frame_start && n < 40) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (!frame_start && n < 100);
    chk("frame_period", n, 32);

    // Tear-free load at idx 2: old digits 2,3 stay until the boundary
    wait_mod(16);
    seg_in = {7'h71, 7'h79, 7'h5E, 7'h39}; load = 1'b1;
    tick();
    load = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (applied) ok = 1'b1;
      else begin
        chk("tear_pending", pending, 1'b1);
        if (an_out == 4'hB) chk("tear_old_d2", seg_out, 7'h24);
        if (an_out == 4'h7) chk("tear_old_d3", seg_out, 7'h79);
        tick();
      end
    end
    chk("tear_applied", ok, 1'b1);
    chk("tear_pending_clr", pending, 1'b0);
    tick();
    chk("tear_new_an", an_out, 4'hE);
    chk("tear_new_seg", seg_out, 7'h46);

    // Load collides with the commit edge
    wait_mod(5);
    seg_in = {7'h01, 7'h02, 7'h04, 7'h3F}; load = 1'b1;
    tick();
    load = 1'b0;
    wait_mod(31);
    seg_in = {7'h08, 7'h10, 7'h20, 7'h06}; load = 1'b1;
    tick();
    load = 1'b0;
    chk("coll_applied", applied, 1'b1);
    chk("coll_pending", pending, 1'b1);
    tick();
    chk("coll_an", an_out, 4'hE);
    chk("coll_old_seg", seg_out, 7'h40);
    wait_applied(ok);
    chk("coll_second_applied", ok, 1'b1);
    chk("coll_pending_clr", pending, 1'b0);
    tick();
    chk("coll_new_seg", seg_out, 7'h79);

    // Blink digit 0: lit 8 of every 16 digit-0 cycles over a 128-cycle period
    seg_in = BASIC; digit_en = 4'hF; blink_en = 4'b0001; brightness = 2'd3; load = 1'b1;
    tick();
    load = 1'b0;
    wait_applied(ok);
    chk("blink_applied", ok, 1'b1);
    n = 0;
    for (int k = 0; k < 128; k++) begin
      tick();
      if (!an_out[0]) n++;
    end
    chk("blink_low_count", n, 16);
    for (int k = 0; k < 200 && ((m_t / 64) % 2) != 1; k++) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("blink_rst_an", an_out, 4'hF);
    chk("blink_rst_seg", seg_out, 7'h7F);
    chk("blink_rst_pending", pending, 1'b0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 499) == 0);
      load = ($urandom_range(0, 19) == 0);
      if (load) begin
        seg_in   = 28'($urandom);
        digit_en = 4'($urandom);
        blink_en = 4'($urandom);
      end
      if ($urandom_range(0, 49) == 0) brightness = 2'($urandom);
      tick();
    end
    rst = 1'b0; load = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for the scoreboard.
- Time-multiplexes NUM_DIGITS digits onto one shared active-low segment bus, with active-low anode selects.
- Adds tear-free frame-synchronous loading, per-digit blanking, per-digit blink and PWM brightness.
- Sits between the score/game logic (producer of digit patterns) and the board display pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..16)
SEG_W, 7, segment bits per digit
SCAN_DIV, 100000, clock cycles per digit slot; must be a multiple of 2**BRIGHT_W
BRIGHT_W, 3, brightness control width
BLINK_HALF, 50000000, clock cycles per blink half-period

Ports:
clk  in  1  system clock; one clock domain
rst  in  1  reset, synchronous, active-high
load  in  1  one-cycle request to capture seg_in/digit_en/blink_en
seg_in  in  NUM_DIGITS*SEG_W  segment patterns, active-high; digit i = seg_in[i*SEG_W +: SEG_W]
digit_en  in  NUM_DIGITS  1 = digit i displayed
blink_en  in  NUM_DIGITS  1 = digit i blinks
brightness  in  BRIGHT_W  duty level; 0 = dimmest lit, all-ones = full on
an_out  out  NUM_DIGITS  anode selects, active-low
seg_out  out  SEG_W  segment drive, active-low
pending  out  1  staged data awaiting frame boundary
applied  out  1  one-cycle pulse: staged data became active
frame_start  out  1  one-cycle pulse as digit 0 slot begins

Behaviour:
- Reset (rst=1 at posedge):
  - an_out and seg_out all ones.
  - Staging and active registers zero.
  - pending, applied, frame_start, blink_phase = 0.
  - All counters and digit index = 0.
- Prescaler: sub_cnt counts 0..SCAN_DIV/2**BRIGHT_W-1. On wrap, phase increments modulo 2**BRIGHT_W.
- Slot tick: sub_cnt and phase both at terminal value.
  - On tick, idx advances, wrapping NUM_DIGITS-1 -> 0.
  - The wrap is the frame boundary.
- Load handshake:
  - load=1 copies seg_in/digit_en/blink_en into staging and sets pending=1.
  - Repeated loads while pending overwrite staging; latest wins.
- Commit: on a frame-boundary tick with pending=1:
  - staging -> active; pending=0; applied=1 for exactly that next cycle.
- Simultaneous load and commit in the same cycle:
  - The commit uses the staging value held before that cycle.
  - The new data enters staging and pending stays 1.
- Active data changes only at frame boundaries; a frame never mixes old and new digits.
- Blink: blink_cnt counts 0..BLINK_HALF-1 and toggles blink_phase on wrap. Free-running; not affected by load.
- Lit condition for current digit: active_en[idx] & (phase <= brightness) & ~(blink_phase & active_blink[idx]).
- Output registration:
  - Outputs are registered one cycle after the counter state that produces them.
  - If lit: an_out = ~(1<<idx), seg_out = ~active_seg[idx].
  - Else: an_out all ones, seg_out all ones.
  - At most one an_out bit is low in any cycle.
- frame_start: one cycle, in the same cycle the registered outputs first show idx=0 of a new frame.
- brightness is sampled live, not staged.
- rst asserted mid-frame returns everything to reset values next cycle. A pending load is discarded.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BRIGHT_W=2, BLINK_HALF=64, brightness=3.
- Reset: hold rst 3 cycles -> an_out=4'hF, seg_out=7'h7F, pending=0. Active data stays zero until the first load and commit; no anode goes low.
- Basic scan: load seg_in={7'h06,7'h5B,7'h4F,7'h66}, digit_en=4'hF, blink_en=0 -> applied pulses at the next frame boundary.
  - Thereafter each slot lasts 8 cycles; an_out cycles E,D,B,7.
  - seg_out is the inverse of each digit's pattern.
  - frame_start fires every 32 cycles.
- Tear-free load: load new data mid-frame (idx=2) -> digits 2,3 still show old data. New data appears from idx=0 with an applied pulse; pending is high in between.
- Load/commit collision: assert load in the exact boundary cycle -> applied=1, the previous staging is shown, pending stays 1, and the new data commits one frame later.
- Brightness: brightness=1 -> the anode is low for 4 of 8 cycles per slot (phases 0-1).
- Blanking and blink:
  - digit_en=4'b0101 -> an_out bits 1 and 3 are never low.
  - blink_en=4'b0001 -> digit 0 is dark for 64-cycle intervals, alternating with lit intervals.
  - Asserting rst during a blink-dark interval returns outputs to all ones.
